// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice race end-of-game logic.
package dice_race_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BLINK,
        HOLD,
        WAIT_BTN,
        RESTART
    } fin_state_t;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;
    localparam winner_t WIN_DRAW = 2'b11;

    localparam int GOAL_TILE_DEF = 10;

    // Wide enough for the longer of the blink and hold periods.
    localparam int FRAME_CNT_W = 8;

    // Per-player finished flags packed as {p2_fin, p1_fin}.
    // Both set in the same cycle encodes a draw.
    function automatic winner_t finish_flags(input logic [3:0] p1,
                                             input logic [3:0] p2,
                                             input logic [3:0] goal);
        return {(p2 >= goal), (p1 >= goal)};
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts frame ticks up to a terminal value.
// Pulses done on the tick that reaches 'last' and wraps itself to zero there.
module frame_tick_counter
    import dice_race_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   tick,
    input  logic [FRAME_CNT_W-1:0] last,
    output logic                   done
);

    logic [FRAME_CNT_W-1:0] cnt_q;
    logic [FRAME_CNT_W-1:0] cnt_d;

    // Terminal count: the counted tick that lands on 'last'.
    always_comb begin
        done = en && tick && (cnt_q == last);
    end

    // Next count: clear wins, else advance per tick and restart on expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && tick) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/finish_sequencer.sv
// End-of-race FINISH banner sequencer: latch winner, blink banner on
// frame boundaries, hold it solid, then request a restart.
module finish_sequencer
    import dice_race_pkg::*;
#(
    parameter int GOAL_TILE    = GOAL_TILE_DEF,
    parameter int BLINK_FRAMES = 15,
    parameter int BLINK_COUNT  = 4,
    parameter int HOLD_FRAMES  = 180,
    parameter bit AUTO_RESTART = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_active,
    input  logic [3:0] p1_pos,
    input  logic [3:0] p2_pos,
    input  logic       restart_btn,
    output logic       finish_en,
    output winner_t    winner,
    output logic       game_over,
    output logic       restart_req,
    output fin_state_t dbg_state
);

    localparam int TOG_W    = $clog2(2 * BLINK_COUNT + 1);
    localparam int TOG_LAST = 2 * BLINK_COUNT - 1;
    localparam logic [3:0] GOAL = 4'(GOAL_TILE);
    localparam logic [FRAME_CNT_W-1:0] BLINK_LAST = FRAME_CNT_W'(BLINK_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] HOLD_LAST  = FRAME_CNT_W'(HOLD_FRAMES - 1);

    fin_state_t       state_q, state_d;
    logic             finish_en_q, finish_en_d;
    winner_t          winner_q, winner_d;
    logic             game_over_q, game_over_d;
    logic             restart_req_q, restart_req_d;
    logic [TOG_W-1:0] tog_q, tog_d;

    logic                   cnt_clr;
    logic                   cnt_en;
    logic                   cnt_done;
    logic [FRAME_CNT_W-1:0] cnt_last;
    winner_t                fin_flags;

    assign fin_flags = finish_flags(p1_pos, p2_pos, GOAL);

    // One frame counter serves both BLINK and HOLD; it idles cleared elsewhere.
    always_comb begin
        cnt_en   = (state_q == BLINK) || (state_q == HOLD);
        cnt_clr  = !cnt_en;
        cnt_last = (state_q == HOLD) ? HOLD_LAST : BLINK_LAST;
    end

    frame_tick_counter u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tick  (frame_tick),
        .last  (cnt_last),
        .done  (cnt_done)
    );

    // Next state and next registered outputs. Abort beats restart_btn,
    // which beats a timer expiry.
    always_comb begin
        state_d     = state_q;
        finish_en_d = finish_en_q;
        winner_d    = winner_q;
        tog_d       = tog_q;

        case (state_q)
            IDLE: begin
                if (game_active && (fin_flags != WIN_NONE)) begin
                    winner_d = fin_flags;
                    state_d  = ARM;
                end
            end
            ARM: begin
                if (!game_active) begin
                    state_d     = IDLE;
                    finish_en_d = 1'b0;
                    winner_d    = WIN_NONE;
                end else if (frame_tick) begin
                    finish_en_d = 1'b1;
                    tog_d       = '0;
                    state_d     = BLINK;
                end
            end
            BLINK: begin
                if (!game_active) begin
                    state_d     = IDLE;
                    finish_en_d = 1'b0;
                    winner_d    = WIN_NONE;
                end else if (cnt_done) begin
                    if (tog_q == TOG_W'(TOG_LAST)) begin
                        // Even number of toggles leaves the banner on.
                        finish_en_d = 1'b1;
                        tog_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        finish_en_d = !finish_en_q;
                        tog_d       = tog_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                finish_en_d = 1'b1;
                if (!game_active) begin
                    state_d     = IDLE;
                    finish_en_d = 1'b0;
                    winner_d    = WIN_NONE;
                end else if (restart_btn) begin
                    state_d = RESTART;
                end else if (cnt_done) begin
                    state_d = AUTO_RESTART ? RESTART : WAIT_BTN;
                end
            end
            WAIT_BTN: begin
                finish_en_d = 1'b1;
                if (!game_active) begin
                    state_d     = IDLE;
                    finish_en_d = 1'b0;
                    winner_d    = WIN_NONE;
                end else if (restart_btn) begin
                    state_d = RESTART;
                end
            end
            RESTART: begin
                finish_en_d = 1'b0;
                winner_d    = WIN_NONE;
                state_d     = IDLE;
            end
            default: begin
                finish_en_d = 1'b0;
                winner_d    = WIN_NONE;
                state_d     = IDLE;
            end
        endcase

        // Registered from the next state so they track the current state.
        restart_req_d = (state_d == RESTART);
        game_over_d   = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            finish_en_q   <= 1'b0;
            winner_q      <= WIN_NONE;
            game_over_q   <= 1'b0;
            restart_req_q <= 1'b0;
            tog_q         <= '0;
        end else begin
            state_q       <= state_d;
            finish_en_q   <= finish_en_d;
            winner_q      <= winner_d;
            game_over_q   <= game_over_d;
            restart_req_q <= restart_req_d;
            tog_q         <= tog_d;
        end
    end

    assign finish_en   = finish_en_q;
    assign winner      = winner_q;
    assign game_over   = game_over_q;
    assign restart_req = restart_req_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_finish_sequencer.sv
// Bench for finish_sequencer: one auto-restart instance and one
// button-restart instance share stimulus; short timing parameters.
module tb_finish_sequencer;
    import dice_race_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       game_active = 1'b0;
    logic [3:0] p1_pos = 4'd0;
    logic [3:0] p2_pos = 4'd0;
    logic       restart_btn = 1'b0;

    logic       fe_a, go_a, rr_a;
    winner_t    win_a;
    fin_state_t st_a;
    logic       fe_b, go_b, rr_b;
    winner_t    win_b;
    fin_state_t st_b;

    int errors = 0;
    int checks = 0;
    int rr_a_cnt = 0;
    int rr_b_cnt = 0;

    logic [3:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    finish_sequencer #(
        .GOAL_TILE(10), .BLINK_FRAMES(2), .BLINK_COUNT(2),
        .HOLD_FRAMES(3), .AUTO_RESTART(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .game_active(game_active), .p1_pos(p1_pos), .p2_pos(p2_pos),
        .restart_btn(restart_btn), .finish_en(fe_a), .winner(win_a),
        .game_over(go_a), .restart_req(rr_a), .dbg_state(st_a)
    );

    finish_sequencer #(
        .GOAL_TILE(10), .BLINK_FRAMES(2), .BLINK_COUNT(2),
        .HOLD_FRAMES(3), .AUTO_RESTART(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .game_active(game_active), .p1_pos(p1_pos), .p2_pos(p2_pos),
        .restart_btn(restart_btn), .finish_en(fe_b), .winner(win_b),
        .game_over(go_b), .restart_req(rr_b), .dbg_state(st_b)
    );

    // Count restart_req high cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && rr_a) rr_a_cnt++;
        if (!reset && rr_b) rr_b_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        game_active = 1'b0;
        p1_pos = 4'd0;
        p2_pos = 4'd0;
        restart_btn = 1'b0;
        frame_tick = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    // Start a race finish by p1 and clear the position so IDLE does not retrigger.
    task automatic start_p1_finish();
        game_active = 1'b1;
        p1_pos = 4'd10;
        cyc(1);
        p1_pos = 4'd0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            cyc(1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({fe_a, win_a, go_a, rr_a} !== 5'b0 || st_a !== IDLE) begin
            errors++;
            $display("FAIL reset_a: got fe=%b win=%b go=%b rr=%b st=%0d expected all 0, IDLE",
                     fe_a, win_a, go_a, rr_a, st_a);
        end
        checks++;
        if ({fe_b, win_b, go_b, rr_b} !== 5'b0 || st_b !== IDLE) begin
            errors++;
            $display("FAIL reset_b: got fe=%b win=%b go=%b rr=%b st=%0d expected all 0, IDLE",
                     fe_b, win_b, go_b, rr_b, st_b);
        end
    endtask

    task automatic test_p1_win();
        logic fe_tab [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp, got;
        int rr_base;
        apply_reset();
        game_active = 1'b1;
        p1_pos = 4'd9;
        cyc(2);
        checks++;
        if (win_a !== WIN_NONE || st_a !== IDLE) begin
            errors++;
            $display("FAIL p1_below_goal: got win=%b st=%0d expected 00 IDLE", win_a, st_a);
        end
        p1_pos = 4'd10;
        cyc(1);
        p1_pos = 4'd0;
        checks++;
        if (win_a !== WIN_P1 || st_a !== ARM || go_a !== 1'b1 || fe_a !== 1'b0) begin
            errors++;
            $display("FAIL p1_latch: got win=%b st=%0d go=%b fe=%b expected 01 ARM 1 0",
                     win_a, st_a, go_a, fe_a);
        end
        cyc(2);
        checks++;
        if (fe_a !== 1'b0) begin
            errors++;
            $display("FAIL arm_wait: got fe=%b expected 0", fe_a);
        end
        rr_base = rr_a_cnt;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({(i == 11), fe_tab[i], WIN_P1});
            pulse_tick();
            got = {rr_a, fe_a, win_a};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL p1_seq[%0d]: got {rr,fe,win}=%b expected %b", i, got, exp);
            end
            cyc(1);
        end
        checks++;
        if ({fe_a, win_a, go_a, rr_a} !== 5'b0 || st_a !== IDLE) begin
            errors++;
            $display("FAIL p1_after_restart: got fe=%b win=%b go=%b rr=%b st=%0d expected 0s IDLE",
                     fe_a, win_a, go_a, rr_a, st_a);
        end
        cyc(4);
        checks++;
        if (rr_a_cnt - rr_base !== 1) begin
            errors++;
            $display("FAIL p1_restart_pulses: got %0d expected 1", rr_a_cnt - rr_base);
        end
    endtask

    task automatic test_draw();
        logic fe_tab [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp, got;
        apply_reset();
        game_active = 1'b1;
        p1_pos = 4'd10;
        p2_pos = 4'd10;
        cyc(1);
        p1_pos = 4'd0;
        p2_pos = 4'd0;
        checks++;
        if (win_a !== WIN_DRAW) begin
            errors++;
            $display("FAIL draw_latch: got win=%b expected 11", win_a);
        end
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({(i == 11), fe_tab[i], WIN_DRAW});
            pulse_tick();
            got = {rr_a, fe_a, win_a};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL draw_seq[%0d]: got {rr,fe,win}=%b expected %b", i, got, exp);
            end
            cyc(1);
        end
        checks++;
        if (win_a !== WIN_NONE || fe_a !== 1'b0) begin
            errors++;
            $display("FAIL draw_clear: got win=%b fe=%b expected 00 0", win_a, fe_a);
        end
    endtask

    task automatic test_wait_btn();
        logic [3:0] exp, got;
        int rr_base;
        apply_reset();
        start_p1_finish();
        rr_base = rr_b_cnt;
        ticks(12);
        checks++;
        if (st_b !== WAIT_BTN || fe_b !== 1'b1 || rr_b !== 1'b0) begin
            errors++;
            $display("FAIL wait_enter: got st=%0d fe=%b rr=%b expected WAIT_BTN 1 0", st_b, fe_b, rr_b);
        end
        for (int i = 0; i < 50; i++) begin
            exp_q.push_back({1'b0, 1'b1, WIN_P1});
            pulse_tick();
            got = {rr_b, fe_b, win_b};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wait_hold[%0d]: got {rr,fe,win}=%b expected %b", i, got, exp);
            end
            cyc($urandom_range(0, 2));
        end
        checks++;
        if (rr_b_cnt !== rr_base) begin
            errors++;
            $display("FAIL wait_no_restart: got %0d pulses expected 0", rr_b_cnt - rr_base);
        end
        restart_btn = 1'b1;
        cyc(1);
        restart_btn = 1'b0;
        checks++;
        if (rr_b !== 1'b1 || fe_b !== 1'b1) begin
            errors++;
            $display("FAIL wait_btn_req: got rr=%b fe=%b expected 1 1", rr_b, fe_b);
        end
        cyc(1);
        checks++;
        if (rr_b !== 1'b0 || fe_b !== 1'b0 || win_b !== WIN_NONE || st_b !== IDLE) begin
            errors++;
            $display("FAIL wait_btn_done: got rr=%b fe=%b win=%b st=%0d expected 0 0 00 IDLE",
                     rr_b, fe_b, win_b, st_b);
        end
    endtask

    task automatic test_abort();
        int rr_base;
        apply_reset();
        start_p1_finish();
        ticks(5);
        checks++;
        if (st_a !== BLINK || fe_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got st=%0d fe=%b expected BLINK 1", st_a, fe_a);
        end
        rr_base = rr_a_cnt;
        game_active = 1'b0;
        cyc(1);
        checks++;
        if (st_a !== IDLE || fe_a !== 1'b0 || win_a !== WIN_NONE || go_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_blink: got st=%0d fe=%b win=%b go=%b expected IDLE 0 00 0",
                     st_a, fe_a, win_a, go_a);
        end
        // Abort and restart_btn together in HOLD: abort wins, no request.
        start_p1_finish();
        ticks(10);
        checks++;
        if (st_a !== HOLD) begin
            errors++;
            $display("FAIL abort_hold_pre: got st=%0d expected HOLD", st_a);
        end
        game_active = 1'b0;
        restart_btn = 1'b1;
        cyc(1);
        restart_btn = 1'b0;
        checks++;
        if (st_a !== IDLE || rr_a !== 1'b0 || fe_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_btn: got st=%0d rr=%b fe=%b expected IDLE 0 0", st_a, rr_a, fe_a);
        end
        cyc(5);
        checks++;
        if (rr_a_cnt !== rr_base) begin
            errors++;
            $display("FAIL abort_no_restart: got %0d pulses expected 0", rr_a_cnt - rr_base);
        end
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        start_p1_finish();
        ticks(10);
        checks++;
        if (st_a !== HOLD || fe_a !== 1'b1) begin
            errors++;
            $display("FAIL hold_pre: got st=%0d fe=%b expected HOLD 1", st_a, fe_a);
        end
        reset = 1'b1;
        cyc(1);
        checks++;
        if ({fe_a, win_a, go_a, rr_a} !== 5'b0 || st_a !== IDLE) begin
            errors++;
            $display("FAIL hold_reset: got fe=%b win=%b go=%b rr=%b st=%0d expected 0s IDLE",
                     fe_a, win_a, go_a, rr_a, st_a);
        end
        reset = 1'b0;
        // restart_btn during BLINK is ignored.
        start_p1_finish();
        ticks(3);
        restart_btn = 1'b1;
        cyc(1);
        restart_btn = 1'b0;
        checks++;
        if (st_a !== BLINK || rr_a !== 1'b0) begin
            errors++;
            $display("FAIL btn_in_blink: got st=%0d rr=%b expected BLINK 0", st_a, rr_a);
        end
        ticks(6);
        checks++;
        if (st_a !== HOLD || fe_a !== 1'b1) begin
            errors++;
            $display("FAIL blink_to_hold: got st=%0d fe=%b expected HOLD 1", st_a, fe_a);
        end
        // restart_btn in HOLD requests a restart the next cycle.
        restart_btn = 1'b1;
        cyc(1);
        restart_btn = 1'b0;
        checks++;
        if (rr_a !== 1'b1 || st_a !== RESTART) begin
            errors++;
            $display("FAIL btn_in_hold: got rr=%b st=%0d expected 1 RESTART", rr_a, st_a);
        end
        cyc(1);
        checks++;
        if (st_a !== IDLE || fe_a !== 1'b0 || rr_a !== 1'b0) begin
            errors++;
            $display("FAIL btn_hold_done: got st=%0d fe=%b rr=%b expected IDLE 0 0", st_a, fe_a, rr_a);
        end
    endtask

    task automatic test_inactive_pos();
        apply_reset();
        p2_pos = 4'd12;
        cyc(3);
        checks++;
        if (st_a !== IDLE || win_a !== WIN_NONE || go_a !== 1'b0) begin
            errors++;
            $display("FAIL inactive_ignore: got st=%0d win=%b go=%b expected IDLE 00 0", st_a, win_a, go_a);
        end
        game_active = 1'b1;
        cyc(1);
        checks++;
        if (win_a !== WIN_P2 || st_a !== ARM || go_a !== 1'b1) begin
            errors++;
            $display("FAIL p2_latch: got win=%b st=%0d go=%b expected 10 ARM 1", win_a, st_a, go_a);
        end
        p2_pos = 4'd0;
        game_active = 1'b0;
        cyc(1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_p1_win();
        test_draw();
        test_wait_btn();
        test_abort();
        test_reset_in_hold();
        test_inactive_pos();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
